// File: rtl/fp_mult_arbiter_pkg.sv
// fp_mult_arbiter_pkg: shared width, rounding-mode encodings, FSM states and default multiplier latency
package fp_mult_arbiter_pkg;
  localparam int WIDTH = 32;
  localparam int MUL_LAT_DEF = 3;
  localparam logic [1:0] RND_RNE = 2'd0;
  localparam logic [1:0] RND_RTZ = 2'd1;
  localparam logic [1:0] RND_RUP = 2'd2;
  localparam logic [1:0] RND_RDN = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;
endpackage

// File: rtl/fp_mult_tag_pipe.sv
// fp_mult_tag_pipe: fixed-depth shift register of {valid, id} tags riding alongside the multiplier
module fp_mult_tag_pipe
  import fp_mult_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [IDW-1:0] in_id,
  output logic           out_valid,
  output logic [IDW-1:0] out_id
);
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0][IDW-1:0] ids;
  // shift tags one stage per cycle; reset drops everything in flight
  always_ff @(posedge clk)
    if (rst) begin
      vld <= '0;
      ids <= '0;
    end else begin
      vld[0] <= in_valid;
      ids[0] <= in_id;
      for (int k = 1; k < DEPTH; k++) begin
        vld[k] <= vld[k-1];
        ids[k] <= ids[k-1];
      end
    end
  assign out_valid = vld[DEPTH-1];
  assign out_id = ids[DEPTH-1];
endmodule

// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter: round-robin sharing of one pipelined FP multiplier; FP_ARB_STATS_EN adds per-requester grant counters
module fp_mult_arbiter
  import fp_mult_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*2-1:0]     req_rnd,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_result,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  output logic [1:0]            mul_rnd,
  input  logic [WIDTH-1:0]      mul_result,
  output logic                  busy,
  output logic                  idle
`ifdef FP_ARB_STATS_EN
  ,
  input  logic [IDW-1:0]        stat_sel,
  output logic [15:0]           stat_cnt
`endif
);
  localparam int OW = $clog2(MUL_LAT + 2);
  state_t state;
  logic [IDW-1:0] ptr, win, tag_id;
  logic hit, grant, tag_valid;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [1:0] sel_rnd;
  logic [OW-1:0] outstanding, out_nxt;
  // lowest valid at or above the pointer wins, else wrap to the lowest valid overall
  always_comb begin
    hit = |req_valid;
    win = ptr;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_valid[k]) win = IDW'(k);
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_valid[k] && IDW'(k) >= ptr) win = IDW'(k);
  end
  assign grant = !rst && en && state == ST_RUN && hit;
  assign req_ready = grant ? NREQ'(1) << win : '0;
  // steer the winner's operands toward the issue registers
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_rnd = '0;
    for (int k = 0; k < NREQ; k++)
      if (win == IDW'(k)) begin
        sel_a = req_a[k*WIDTH +: WIDTH];
        sel_b = req_b[k*WIDTH +: WIDTH];
        sel_rnd = req_rnd[k*2 +: 2];
      end
  end
  assign out_nxt = outstanding + OW'(grant) - OW'(tag_valid);
  // issue registers, round-robin pointer, in-flight count and enable/drain FSM
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_IDLE;
      ptr <= '0;
      outstanding <= '0;
      mul_a <= '0;
      mul_b <= '0;
      mul_rnd <= '0;
    end else begin
      outstanding <= out_nxt;
      if (grant) begin
        mul_a <= sel_a;
        mul_b <= sel_b;
        mul_rnd <= sel_rnd;
        ptr <= win == IDW'(NREQ - 1) ? '0 : win + 1'b1;
      end
      case (state)
        ST_IDLE: if (en) state <= ST_RUN;
        ST_RUN: if (!en) state <= ST_DRAIN;
        ST_DRAIN: state <= en ? ST_RUN : out_nxt == '0 ? ST_IDLE : ST_DRAIN;
        default: state <= ST_IDLE;
      endcase
    end
  fp_mult_tag_pipe #(.DEPTH(1 + MUL_LAT), .IDW(IDW)) u_tag (
    .clk(clk),
    .rst(rst),
    .in_valid(grant),
    .in_id(win),
    .out_valid(tag_valid),
    .out_id(tag_id)
  );
  assign rsp_valid = tag_valid && !rst ? NREQ'(1) << tag_id : '0;
  assign rsp_result = mul_result;
  assign busy = outstanding != '0 || state != ST_IDLE;
  assign idle = !busy;
`ifdef FP_ARB_STATS_EN
  logic [NREQ-1:0][15:0] cnt;
  // saturating per-requester grant counters with a registered readout
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      stat_cnt <= '0;
    end else begin
      stat_cnt <= cnt[stat_sel];
      for (int k = 0; k < NREQ; k++)
        if (req_ready[k] && cnt[k] != 16'hFFFF) cnt[k] <= cnt[k] + 16'd1;
    end
`endif
endmodule

// File: doc/fp_mult_arbiter.md
Name: fp_mult_arbiter

Overview:
- Shares one fully pipelined 32-bit FP multiplier (operands A/B, 2-bit rnd, fixed latency) among NREQ requesters.
- Round-robin grants one operation per cycle and registers the winner's operands into the multiplier.
- Tags each in-flight op with its requester ID and steers the result back as a one-cycle response pulse.
- An enable/drain state machine quiesces the multiplier cleanly for reconfiguration or power-down.

Parameters:
- WIDTH, 32, operand/result width (shared parameters package).
- NREQ, 4, number of requesters (2..8).
- MUL_LAT, 3, multiplier latency in cycles: operands on mul_a/mul_b/mul_rnd at cycle k give mul_result at cycle k+MUL_LAT.
- IDW, $clog2(NREQ), requester ID width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  1 = arbitrate; 0 = stop granting and drain.
- req_valid  in  NREQ  per-requester operation valid.
- req_a  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same packing.
- req_rnd  in  NREQ*2  rounding mode, requester i at [2i +: 2].
- req_ready  out  NREQ  one-hot grant; handshake when valid&ready.
- rsp_valid  out  NREQ  one-hot, one-cycle result pulse to the owning requester.
- rsp_result  out  WIDTH  result, broadcast to all requesters; qualified by rsp_valid.
- mul_a  out  WIDTH  multiplier operand A (registered).
- mul_b  out  WIDTH  multiplier operand B (registered).
- mul_rnd  out  2  multiplier rounding mode (registered).
- mul_result  in  WIDTH  multiplier output.
- busy  out  1  ops in flight, or state not IDLE.
- idle  out  1  state IDLE and pipeline empty.

Behaviour:
- Reset:
  - Outputs: req_ready=0, rsp_valid=0, mul_a/mul_b/mul_rnd=0, busy=0, idle=1.
  - Internal: RR pointer=0, tag pipe cleared, outstanding=0, state=IDLE.
  - rst mid-operation discards all in-flight tags, so no rsp_valid appears for them.
- States:
  - IDLE:
    - No grants.
    - en=1 -> RUN.
  - RUN:
    - Grants allowed.
    - en=0 -> DRAIN.
  - DRAIN:
    - No grants.
    - en=1 -> RUN. A re-enable during drain is allowed.
    - outstanding==0 -> IDLE.
- Arbitration:
  - Only in RUN.
  - req_ready[i] is combinational from req_valid, state and RR pointer.
  - Searches from the pointer upward, wrapping modulo NREQ.
  - The first valid requester wins; at most one bit is set.
  - On a grant to i, the pointer becomes (i+1) mod NREQ.
  - No grant leaves the pointer unchanged.
- Issue:
  - A grant at cycle t registers the winner's operands so they appear on mul_* at t+1.
  - With no grant, mul_* hold their values; the tag valid is 0.
- Tag pipe:
  - Depth 1+MUL_LAT, each stage {valid, id}.
  - The stage output aligns with mul_result at cycle t+1+MUL_LAT.
  - Total request-to-response latency: 1+MUL_LAT cycles (4 by default).
- Response:
  - rsp_valid[id] = tag_out_valid, decoded one-hot.
  - rsp_result = mul_result, combinational.
  - Requesters have no backpressure; they must accept the pulse.
- Throughput and outstanding count:
  - Throughput is 1 op/cycle.
  - outstanding increments on a grant and decrements on a response.
  - On a simultaneous grant and response it is unchanged.
  - It never exceeds 1+MUL_LAT.
- Edge cases:
  - A requester whose valid drops without a handshake is simply not served.
  - en dropping in the same cycle as a request means no grant that cycle, because the state register is still RUN but the grant is gated by en.

Optional Feature:
- FP_ARB_STATS_EN: adds a per-requester 16-bit saturating grant counter.
- Extra ports when defined: stat_sel (in, IDW) and stat_cnt (out, 16); stat_cnt is registered and is the counter for stat_sel.
- Counter behaviour: cleared on rst, saturates at 16'hFFFF.
- Without the macro: no counters and no stat ports; behaviour is otherwise identical.

Decomposition:
- Shared package/parameters file:
  - WIDTH, rounding-mode encodings (RNE/RTZ/RUP/RDN).
  - State encoding constants ST_IDLE/ST_RUN/ST_DRAIN.
  - Default MUL_LAT.
- One sub-module, fp_mult_tag_pipe: parameterized-depth shift register of {valid, id} with synchronous clear.

Test Plan:
1. Single requester:
   - Stimulus: en=1; req 0 sends A=0x3FC00000 (1.5), B=0x40000000 (2.0), rnd=0 at t.
   - Response: req_ready[0]=1 at t; rsp_valid=4'b0001 with rsp_result=0x40400000 (3.0) at t+4.
2. All four requesters valid continuously for 8 cycles from pointer 0:
   - Grants in order 0,1,2,3,0,1,2,3.
   - Each response returns to its issuer 4 cycles later with that issuer's product.
3. Requesters 1 and 3 valid, pointer=2:
   - Grant 3, then 1, then 3.
   - The pointer skips the idle requesters.
4. Drain:
   - Stimulus: 3 back-to-back grants, then en=0.
   - Response: no further req_ready; 3 responses still delivered; state reaches IDLE, idle=1, busy=0 the cycle after the last response.
5. Reset with ops in flight:
   - Stimulus: rst pulse while 2 ops are in flight.
   - Response: no rsp_valid afterwards; all outputs at reset values; pointer=0.
6. FP_ARB_STATS_EN build:
   - Stimulus: 5 grants to requester 2; stat_sel=2.
   - Response: stat_cnt=5 one cycle later.
